instr_fetch: RTL
================

Name: instr_fetch

Overview:
Instruction-fetch stage that feeds the instruction decoder/ALU stage (p2). It holds the PC and a small loadable instruction memory, and presents one 32-bit instruction per accepted handshake on a valid/ready output register. The downstream stage resolves beq/j and returns a redirect target, which flushes the in-flight word and restarts fetch at the target.

Parameters:
DEPTH, 64, instruction memory depth in 32-bit words (power of 2).
AW, 6, word-address width, log2(DEPTH).
RESET_PC, 32'h0000_0000, byte address fetched first after start.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous active-high reset.
start  input  1  leave IDLE and begin fetching at RESET_PC.
imem_we  input  1  instruction memory write enable (program load).
imem_waddr  input  AW  word address for program load.
imem_wdata  input  32  program word.
out_valid  output  1  out_instr/out_pc hold a valid fetched word.
out_ready  input  1  downstream accepts the word this cycle.
out_instr  output  32  fetched instruction, the decoder's i input.
out_pc  output  32  byte address of out_instr.
redirect_valid  input  1  branch taken or jump from downstream.
redirect_target  input  32  new byte PC.
halted  output  1  fetch stopped: PC past end of memory.
fetch_count  output  16  accepted handshakes, saturating at 16'hFFFF.

Behaviour:
- Reset (async, any state): state=IDLE, pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, halted=0, fetch_count=0. Memory contents are not reset.
- States: IDLE, FETCH, HALT.
- IDLE: outputs idle. On start=1, go to FETCH. The first word is loaded the following cycle. start is ignored in other states.
- FETCH: the output register may load when (!out_valid || out_ready).
  - In-range load (pc < DEPTH*4): out_instr=imem[pc[AW+1:2]], out_pc=pc, out_valid=1, pc=pc+4.
  - Out-of-range load: out_valid=0, halted=1, go to HALT.
  - Latency: one cycle from the pc update to out_valid.
  - With out_ready held high, one word is issued per cycle.
- Stall: out_valid && !out_ready keeps out_instr, out_pc, out_valid and pc unchanged.
- Handshake: out_valid && out_ready. fetch_count increments by 1 and saturates.
- Redirect (FETCH or HALT, highest priority):
  - Next cycle: pc=redirect_target with bits[1:0] forced to 0, out_valid=0, halted=0, state=FETCH.
  - If out_valid && out_ready in the same cycle, that handshake still counts.
  - The target word appears at the earliest 2 cycles after redirect_valid.
  - A redirect to an out-of-range target re-enters HALT on the next load.
  - Redirect in IDLE is ignored.
- HALT: out_valid=0 and halted=1 until a redirect or reset.
- Memory:
  - Combinational read, synchronous write.
  - A write to the word being read in the same cycle: the fetch returns the old word.
  - Writes are allowed in any state.
- pc arithmetic is 32-bit and wraps modulo 2^32. Wrap is unreachable in practice because the out-of-range check halts first.

Decomposition:
- Shared package (fetch_pkg):
  - fetch_state_t enum {IDLE, FETCH, HALT}.
  - Constant PC_STEP=4.
  - Opcode constants OP_RTYPE=6'h00, OP_LW=6'h23, OP_SW=6'h2B, OP_BEQ=6'h04, OP_J=6'h02, shared with the decoder.
- Sub-module imem_rom: DEPTH x 32 array with one write port and a combinational read port. All control stays in instr_fetch.

Test Plan:
1. Reset, then load words 0..4 = 02328020, 8E300020, AE300020, 121100C8, 080003E8. Pulse start with out_ready=1.
   -> Words appear on consecutive cycles with out_pc 0,4,8,C,10. fetch_count reaches 5.
2. Same program, out_ready=0 for 3 cycles while word 1 is valid.
   -> out_instr holds 8E300020 and out_pc 4 for all 3 cycles. pc does not advance. After release, word 2 follows next cycle.
3. While word 4 (080003E8) is valid, pulse redirect_valid with target 32'h0000_0003 and out_ready=1.
   -> Next cycle out_valid=0. Then out_instr=02328020, out_pc=0. fetch_count counts the word-4 handshake.
4. DEPTH=64, run past address 0xFC.
   -> After word 63 is accepted, out_valid=0 and halted=1. Redirect to 0x8 clears halted and re-fetches AE300020.
5. Assert rst mid-stream while out_valid=1.
   -> All outputs go to 0 immediately, no clock needed. State is IDLE, and nothing is fetched until start.
6. Write imem[1]=DEADBEEF in the same cycle pc=4 is loaded.
   -> out_instr=8E300020 (old word). A later redirect to 4 returns DEADBEEF.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch state, PC step and opcode constants for the fetch/decode stages
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, HALT} fetch_state_t;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_J = 6'h02;
endpackage

// File: rtl/imem_rom.sv
// imem_rom: instruction store with synchronous program-load write and combinational read
module imem_rom #(
  parameter int DEPTH = 64,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC + instruction memory feeding a valid/ready output register, with redirect flush
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int          DEPTH = 64,
  parameter int          AW = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          imem_we,
  input  logic [AW-1:0] imem_waddr,
  input  logic [31:0]   imem_wdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_pc,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_target,
  output logic          halted,
  output logic [15:0]   fetch_count
);
  fetch_state_t state, state_n;
  logic [31:0] pc, pc_n, instr_n, opc_n, rdata;
  logic        valid_n, halted_n, load, in_range, hs;
  logic [15:0] count_n;
  assign hs = out_valid && out_ready;
  assign load = !out_valid || out_ready;
  assign in_range = pc < 32'(DEPTH * 4);
  imem_rom #(.DEPTH(DEPTH), .AW(AW)) u_rom (
    .clk(clk),
    .we(imem_we),
    .waddr(imem_waddr),
    .wdata(imem_wdata),
    .raddr(pc[AW+1:2]),
    .rdata(rdata)
  );
  always_comb begin
    state_n = state;
    pc_n = pc;
    instr_n = out_instr;
    opc_n = out_pc;
    valid_n = out_valid;
    halted_n = halted;
    count_n = (hs && fetch_count != 16'hFFFF) ? fetch_count + 16'd1 : fetch_count;
    if (state == IDLE) begin
      state_n = start ? FETCH : IDLE;
    end else if (redirect_valid) begin
      state_n = FETCH;
      pc_n = redirect_target & ~32'd3;
      valid_n = 1'b0;
      halted_n = 1'b0;
    end else if (state == HALT) begin
      valid_n = 1'b0;
      halted_n = 1'b1;
    end else if (load && in_range) begin
      instr_n = rdata;
      opc_n = pc;
      valid_n = 1'b1;
      pc_n = pc + PC_STEP;
    end else if (load) begin
      valid_n = 1'b0;
      halted_n = 1'b1;
      state_n = HALT;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc <= '0;
      halted <= 1'b0;
      fetch_count <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      out_valid <= valid_n;
      out_instr <= instr_n;
      out_pc <= opc_n;
      halted <= halted_n;
      fetch_count <= count_n;
    end
endmodule
